posit_sqrt_encoder: RTL and testbench



---
 rtl/posit_sqrt_encoder.sv | 122 ++++++++++++
 tb/tb_posit_sqrt_encoder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/posit_sqrt_encoder.sv
// Posit packer for the sqrt path: regime-encodes decoded fields, rounds to nearest-even,
// saturates and negates into an N-bit posit through a two-stage valid/ready pipeline.

typedef enum logic [1:0] {
    POSIT32 = 2'd0,
    POSIT16 = 2'd1,
    POSIT8  = 2'd2
} posit_format_e;

function automatic int posit_width(posit_format_e f);
    case (f)
        POSIT16: return 16;
        POSIT8:  return 8;
        default: return 32;
    endcase
endfunction

function automatic int exp_bits(posit_format_e f);
    case (f)
        default: return 2;
    endcase
endfunction

// Handshake: a beat moves across any boundary only when valid and ready are both high
// on the same clk_i edge; valid must not depend on ready, and a stalled output holds.
module posit_sqrt_encoder #(
    parameter posit_format_e pFormat = posit_format_e'(0)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  in_valid_i,
    output logic                                  in_ready_o,
    input  logic                                  sign_i,
    input  logic                                  zero_i,
    input  logic                                  nar_i,
    input  logic                                  sign_exp_i,
    input  logic [$clog2(posit_width(pFormat))+4:0] regime_i,
    input  logic [exp_bits(pFormat)-1:0]          exp_i,
    input  logic [2*posit_width(pFormat)-1:0]     mant_i,
    output logic                                  out_valid_o,
    input  logic                                  out_ready_i,
    output logic [posit_width(pFormat)-1:0]       posit_o
);
    localparam int N  = posit_width(pFormat);
    localparam int ES = exp_bits(pFormat);
    localparam int RS = $clog2(N);
    localparam int WB = ES + 2*N;      // terminator + exponent + fraction
    localparam int W  = N - 1 + WB;    // room for the longest regime run

    logic s1_en, s2_en;
    logic s1_valid;
    logic [N-2:0] s1_body;
    logic s1_guard, s1_sticky, s1_sign, s1_zero, s1_nar;

    logic unused_hidden;
    assign unused_hidden = mant_i[2*N-1];

    assign s2_en      = !out_valid_o || out_ready_i;
    assign s1_en      = !s1_valid || s2_en;
    assign in_ready_o = s1_en;

    logic [RS+4:0] r_clamp;
    logic [W-1:0]  run_mask, shifted, full;
    logic [N-2:0]  body;
    logic          guard, sticky;

    // Right-shifting the terminator+tail by R leaves exactly R run bits on top.
    always_comb begin
        r_clamp  = (regime_i > (RS+5)'(N-1)) ? (RS+5)'(N-1) : regime_i;
        run_mask = ~({W{1'b1}} >> r_clamp);
        shifted  = {sign_exp_i, exp_i, mant_i[2*N-2:0], {(N-1){1'b0}}} >> r_clamp;
        full     = sign_exp_i ? shifted : (shifted | run_mask);
        body     = full[W-1 -: N-1];
        guard    = full[W-N];
        sticky   = |full[W-N-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (in_valid_i && in_ready_o) begin
            s1_body   <= body;
            s1_guard  <= guard;
            s1_sticky <= sticky;
            s1_sign   <= sign_i;
            s1_zero   <= zero_i;
            s1_nar    <= nar_i;
        end
    end

    logic [N-2:0] rounded;
    logic [N-1:0] packed_res, result;

    // All-ones body is maxpos and must not carry into the sign bit; zero becomes minpos.
    always_comb begin
        rounded = s1_body;
        if (!(&s1_body))
            rounded = s1_body + (N-1)'(s1_guard & (s1_sticky | s1_body[0]));
        if (rounded == '0)
            rounded = (N-1)'(1);
        packed_res = {1'b0, rounded};
        result     = s1_sign ? (~packed_res + N'(1)) : packed_res;
        if (s1_nar)
            result = {1'b1, {(N-1){1'b0}}};
        else if (s1_zero)
            result = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid    <= 1'b0;
            out_valid_o <= 1'b0;
            posit_o     <= '0;
        end else begin
            if (s1_en)
                s1_valid <= in_valid_i;
            if (s2_en) begin
                out_valid_o <= s1_valid;
                if (s1_valid)
                    posit_o <= result;
            end
        end
    end
endmodule

// File: tb/tb_posit_sqrt_encoder.sv
// Bench for posit_sqrt_encoder (N=32, ES=2): directed encodings, backpressure, reset
// mid-flight and random streaming against a bit-serial reference model.
module tb_posit_sqrt_encoder;
    localparam int N  = 32;
    localparam int ES = 2;
    localparam int RS = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0, in_ready;
    logic sign = 1'b0, zero = 1'b0, nar = 1'b0, sign_exp = 1'b0;
    logic [RS+4:0] regime = '0;
    logic [ES-1:0] expo = '0;
    logic [2*N-1:0] mant = '0;
    logic out_valid, out_ready = 1'b0;
    logic [N-1:0] posit;

    int total = 0;
    int bad = 0;
    logic [N-1:0] exp_q[$];
    bit rnd_on = 1'b0;

    localparam logic [63:0] ONE = 64'h8000000000000000;

    posit_sqrt_encoder dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .sign_i(sign), .zero_i(zero), .nar_i(nar), .sign_exp_i(sign_exp),
        .regime_i(regime), .exp_i(expo), .mant_i(mant),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .posit_o(posit)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Reference: walk the posit bit stream one bit at a time.
    function automatic logic [N-1:0] ref_enc(input logic sg, input logic z, input logic na,
                                             input logic se, input logic [RS+4:0] r,
                                             input logic [ES-1:0] e, input logic [2*N-1:0] m);
        logic [N-2:0] bd;
        logic g, s, b;
        logic [N-1:0] p;
        int rr;
        if (na) return {1'b1, {(N-1){1'b0}}};
        if (z) return '0;
        rr = (int'(r) > N-1) ? N-1 : int'(r);
        bd = '0; g = 1'b0; s = 1'b0;
        for (int i = 0; i < 3*N+ES; i++) begin
            if (i < rr) b = ~se;
            else if (i == rr) b = se;
            else if (i < rr+1+ES) b = e[ES-1-(i-rr-1)];
            else if (i < rr+ES+2*N) b = m[2*N-2-(i-rr-1-ES)];
            else b = 1'b0;
            if (i < N-1) bd[N-2-i] = b;
            else if (i == N-1) g = b;
            else s = s | b;
        end
        if (bd != {(N-1){1'b1}}) bd = bd + (N-1)'(g & (s | bd[0]));
        if (bd == '0) bd = (N-1)'(1);
        p = {1'b0, bd};
        if (sg) p = -p;
        return p;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("spurious_out", 64'(out_valid), 64'(0));
                else check("stream", 64'(posit), 64'(exp_q.pop_front()));
            end
            if (in_valid && in_ready)
                exp_q.push_back(ref_enc(sign, zero, nar, sign_exp, regime, expo, mant));
        end
    end

    always @(posedge clk) begin
        if (rnd_on) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic set_in(input logic sg, input logic z, input logic na, input logic se,
                          input int r, input int e, input logic [63:0] m);
        sign = sg; zero = z; nar = na; sign_exp = se;
        regime = (RS+5)'(r); expo = ES'(e); mant = m;
        in_valid = 1'b1;
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input logic sg, input logic z, input logic na, input logic se,
                        input int r, input int e, input logic [63:0] m);
        int n;
        set_in(sg, z, na, se, r, e, m);
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                check("send_timeout", 64'(in_ready), 64'(1));
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic dir(input string tag, input logic sg, input logic z, input logic na,
                       input logic se, input int r, input int e, input logic [63:0] m,
                       input logic [N-1:0] want);
        out_ready = 1'b1;
        send(sg, z, na, se, r, e, m);
        check({tag, "_early"}, 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        check({tag, "_valid"}, 64'(out_valid), 64'(1));
        check(tag, 64'(posit), 64'(want));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [N-1:0] held;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_posit", 64'(posit), 64'(0));
        check("rst_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1;

        dir("one",      0, 0, 0, 0, 1,  0, ONE, 32'h40000000);
        dir("exp2",     0, 0, 0, 0, 1,  2, ONE, 32'h50000000);
        dir("negreg",   0, 0, 0, 1, 1,  2, ONE, 32'h30000000);
        dir("sqrt2",    0, 0, 0, 0, 1,  0, 64'hB504F333F9DE6800, 32'h43504F33);
        dir("rnd_up",   0, 0, 0, 0, 1,  0, 64'h8000001800000000, 32'h40000002);
        dir("rnd_tie",  0, 0, 0, 0, 1,  0, 64'h8000000800000000, 32'h40000000);
        dir("maxpos",   0, 0, 0, 0, 40, 0, ONE, 32'h7FFFFFFF);
        dir("minpos",   0, 0, 0, 1, 40, 0, ONE, 32'h00000001);
        dir("neg_one",  1, 0, 0, 0, 1,  0, ONE, 32'hC0000000);
        dir("zero",     0, 1, 0, 0, 1,  0, ONE, 32'h00000000);
        dir("nar",      0, 1, 1, 0, 1,  0, ONE, 32'h80000000);

        // Backpressure: four offers, output stalled for five cycles.
        out_ready = 1'b0;
        set_in(0, 0, 0, 0, 1, 1, ONE);
        @(negedge clk); check("bp_rdy0", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        set_in(0, 0, 0, 0, 2, 0, ONE);
        @(negedge clk); check("bp_rdy1", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        set_in(1, 0, 0, 1, 2, 3, 64'hC000000000000000);
        @(negedge clk);
        check("bp_full", 64'(in_ready), 64'(0));
        check("bp_valid", 64'(out_valid), 64'(1));
        held = posit;
        repeat (2) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("bp_full_hold", 64'(in_ready), 64'(0));
            check("bp_stable", 64'(posit), 64'(held));
            check("bp_valid_hold", 64'(out_valid), 64'(1));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check("bp_drain_valid", 64'(out_valid), 64'(1));
            if (j < 2) check("bp_drain_rdy", 64'(in_ready), 64'(1));
            @(posedge clk); #1;
            if (j == 0) set_in(0, 0, 0, 1, 3, 1, 64'hFFFFFFFFFFFFFFFF);
            if (j == 1) in_valid = 1'b0;
        end
        check("bp_empty", 64'(exp_q.size()), 64'(0));

        // Reset with two items in flight.
        out_ready = 1'b0;
        send(0, 0, 0, 0, 5, 1, ONE);
        send(1, 0, 0, 0, 6, 2, ONE);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mrst_valid", 64'(out_valid), 64'(0));
        check("mrst_posit", 64'(posit), 64'(0));
        check("mrst_ready", 64'(in_ready), 64'(1));
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("mrst_no_stale", 64'(out_valid), 64'(0));

        // Random streaming with random backpressure.
        rnd_on = 1'b1;
        for (int i = 0; i < 100; i++) begin
            send(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
                 $urandom_range(1, 40), $urandom_range(0, 3),
                 {1'b1, 31'($urandom), 32'($urandom)});
            repeat ($urandom_range(0, 1)) begin
                @(posedge clk); #1;
            end
        end
        for (int k = 0; k < 2000 && exp_q.size() != 0; k++) @(posedge clk);
        rnd_on = 1'b0;
        #2;
        out_ready = 1'b1;
        check("stream_drained", 64'(exp_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
